// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the WIDTH-bit carry chain is cut into STAGES chunks, one chunk per
// register rank, behind a valid/ready handshake that freezes the whole pipe on output stall.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_cin,
  input  logic             io_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_sum,
  output logic             io_cout,
  output logic             io_ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Rank 0 captures the operands; rank r (1..STAGES) has finished chunk r-1.
  logic             valid_q [STAGES+1];
  logic             valid_d [STAGES+1];
  logic [WIDTH-1:0] a_q     [STAGES+1];
  logic [WIDTH-1:0] a_d     [STAGES+1];
  logic [WIDTH-1:0] b_q     [STAGES+1];
  logic [WIDTH-1:0] b_d     [STAGES+1];
  logic [WIDTH-1:0] sum_q   [STAGES+1];
  logic [WIDTH-1:0] sum_d   [STAGES+1];
  logic             carry_q [STAGES+1];
  logic             carry_d [STAGES+1];
  logic             ovf_q;
  logic             ovf_d;
  logic             stall;
  logic [CHUNK:0]   chunk_sum;

  always_comb begin
    stall       = valid_q[STAGES] & ~io_out_ready;
    io_in_ready = ~stall & ~reset;

    valid_d[0] = io_in_valid & io_in_ready;
    a_d[0]     = io_a;
    b_d[0]     = io_sub ? ~io_b : io_b;
    sum_d[0]   = '0;
    carry_d[0] = io_cin;

    chunk_sum = '0;
    for (int unsigned r = 1; r <= STAGES; r++) begin
      chunk_sum = {1'b0, a_q[r-1][(r-1)*CHUNK +: CHUNK]}
                + {1'b0, b_q[r-1][(r-1)*CHUNK +: CHUNK]}
                + (CHUNK+1)'(carry_q[r-1]);
      valid_d[r] = valid_q[r-1];
      a_d[r]     = a_q[r-1];
      b_d[r]     = b_q[r-1];
      sum_d[r]   = sum_q[r-1];
      sum_d[r][(r-1)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      carry_d[r] = chunk_sum[CHUNK];
    end

    // a^b^sum at the MSB recovers the carry into the MSB without a separate tap.
    ovf_d = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
          ^ sum_d[STAGES][WIDTH-1] ^ carry_d[STAGES];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r <= STAGES; r++) begin
        valid_q[r] <= '0;
        a_q[r]     <= '0;
        b_q[r]     <= '0;
        sum_q[r]   <= '0;
        carry_q[r] <= '0;
      end
      ovf_q <= '0;
    end else if (!stall) begin
      for (int unsigned r = 0; r <= STAGES; r++) begin
        valid_q[r] <= valid_d[r];
        a_q[r]     <= a_d[r];
        b_q[r]     <= b_d[r];
        sum_q[r]   <= sum_d[r];
        carry_q[r] <= carry_d[r];
      end
      ovf_q <= ovf_d;
    end
  end

  assign io_out_valid = valid_q[STAGES];
  assign io_sum       = sum_q[STAGES];
  assign io_cout      = carry_q[STAGES];
  assign io_ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder at WIDTH=8, STAGES=2.
module tb_pipelined_adder;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_a         (a),
    .io_b         (b),
    .io_cin       (cin),
    .io_sub       (sub),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_sum       (sum),
    .io_cout      (cout),
    .io_ovf       (ovf)
  );

  // Issues one beat into an empty pipe and waits (bounded) for its result; the result is
  // consumed before returning so the pipe is empty again.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic tsub, output logic acc, output logic [W-1:0] rs,
                        output logic rc, output logic ro, output int lat, output logic got);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    #1 acc = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; got = 1'b0; rs = '0; rc = 1'b0; ro = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) begin
        got = 1'b1; rs = sum; rc = cout; ro = ovf;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_arith;
    logic [W-1:0] va [9];
    logic [W-1:0] vb [9];
    logic         vc [9];
    logic         vs [9];
    logic [W-1:0] es [9];
    logic         ec [9];
    logic         eo [9];
    logic         acc;
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    int           lat;
    logic         got;
    va = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h07, 8'h0F, 8'h0F, 8'h80, 8'h00};
    vb = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h05, 8'h01, 8'h00, 8'h01, 8'h00};
    vc = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    vs = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    es = '{8'h00, 8'h80, 8'h00, 8'hFE, 8'h02, 8'h10, 8'h10, 8'h7F, 8'hFF};
    ec = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    eo = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], vc[i], vs[i], acc, rs, rc, ro, lat, got);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL arith%0d_accept: in_ready %b expected 1", i, acc); end
      checks++;
      if (!got) begin
        errors++; $display("FAIL arith%0d_timeout: no out_valid within 20 cycles", i);
      end else begin
        if (lat != S) begin errors++; $display("FAIL arith%0d_latency: got %0d expected %0d", i, lat, S); end
        checks++; if (rs !== es[i]) begin errors++; $display("FAIL arith%0d_sum: got %h expected %h", i, rs, es[i]); end
        checks++; if (rc !== ec[i]) begin errors++; $display("FAIL arith%0d_cout: got %b expected %b", i, rc, ec[i]); end
        checks++; if (ro !== eo[i]) begin errors++; $display("FAIL arith%0d_ovf: got %b expected %b", i, ro, eo[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int k = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 10) begin
        in_valid = 1'b1; a = 8'(c); b = 8'(2 * c); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 10) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected 1", c, in_ready); end
      end
      if (out_valid === 1'b1) begin
        checks++; if (sum !== 8'(3 * k)) begin errors++; $display("FAIL b2b_sum%0d: got %h expected %h", k, sum, 8'(3 * k)); end
        checks++; if (c != k + 3) begin errors++; $display("FAIL b2b_slot%0d: seen at cycle %0d expected %0d", k, c, k + 3); end
        k++;
      end
    end
    checks++; if (k != 10) begin errors++; $display("FAIL b2b_count: got %0d results expected 10", k); end
  endtask

  task automatic test_stall;
    int           in_idx = 0;
    int           out_idx = 0;
    int           stalled = 0;
    int           extra = 0;
    logic [W-1:0] held = '0;
    logic         have_held = 1'b0;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 8);
      if (in_idx < 6) begin
        in_valid = 1'b1; a = 8'(8'h10 + in_idx); b = 8'(in_idx); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stalled++;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0 at cycle %0d", in_ready, c); end
        if (have_held) begin
          checks++; if (sum !== held) begin errors++; $display("FAIL stall_stable: got %h expected %h at cycle %0d", sum, held, c); end
        end
        held = sum; have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sum !== 8'(8'h10 + 2 * out_idx)) begin
          errors++; $display("FAIL stall_sum%0d: got %h expected %h", out_idx, sum, 8'(8'h10 + 2 * out_idx));
        end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (stalled != 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", stalled); end
    checks++; if (out_idx != 6) begin errors++; $display("FAIL stall_emitted: got %0d expected 6", out_idx); end
    repeat (5) begin
      @(negedge clk);
      #1 if (out_valid === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL stall_duplicates: got %0d extra beats expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int           spurious = 0;
    logic         acc;
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    int           lat;
    logic         got;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    @(negedge clk);
    reset = 1'b1; a = 8'h33; b = 8'h01;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid === 1'b1) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale beats expected 0", spurious); end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, acc, rs, rc, ro, lat, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL rstmid_timeout: no out_valid within 20 cycles");
    end else if (rs !== 8'h30 || rc !== 1'b0 || ro !== 1'b0 || lat != S) begin
      errors++; $display("FAIL rstmid_result: got sum=%h cout=%b ovf=%b lat=%0d expected 30 0 0 %0d", rs, rc, ro, lat, S);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
